pingpong_frame_bram: RTL
========================

PINGPONG_FRAME_BRAM -- requirements
Module: pingpong_frame_bram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 22, meaning pixel/feature word width in bits.
REQ-002 SHALL have parameter DEPTH, default 147708, meaning words per frame bank.
REQ-003 SHALL have parameter ADDR_WIDTH, default 18, meaning address width; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port wr_valid  input  1  write strobe.
REQ-007 SHALL have port wr_addr  input  ADDR_WIDTH  write word address within current write bank.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-009 SHALL have port wr_frame_done  input  1  one-cycle pulse; writer finished current frame.
REQ-010 SHALL have port wr_ready  output  1  a write bank is owned by the writer.
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  read word address within current read bank.
REQ-013 SHALL have port rd_frame_done  input  1  one-cycle pulse; reader releases current read bank.
REQ-014 SHALL have port frame_ready  output  1  a complete frame is held in the read bank.
REQ-015 SHALL have port rd_data  output  DATA_WIDTH  read data.
REQ-016 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-017 SHALL have port drop_cnt  output  16  count of discarded writes, saturating at 0xFFFF.
REQ-018 SHALL have port addr_err  output  1  sticky; any out-of-range write or read address seen.

Function
REQ-019 SHALL hold two banks of DEPTH x DATA_WIDTH words (bank 0, bank 1) with bank indices wb (write) and rb (read).
REQ-020 SHALL implement states EMPTY (writer owns wb, no full frame), ONE (writer owns wb, rb = other bank full), TWO (both banks full, writer has none).
REQ-021 EMPTY: wr_frame_done -> ONE, rb<=wb, wb<=~wb; rd_frame_done ignored.
REQ-022 ONE: wr_frame_done only -> TWO; rd_frame_done only -> EMPTY, rb unchanged; both same cycle -> stay ONE, rb<=wb, wb<=~wb.
REQ-023 TWO: rd_frame_done -> ONE, rb<=~rb, wb<=old rb; wr_frame_done ignored.
REQ-024 wr_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; frame_ready SHALL be 1 in ONE and TWO.
REQ-025 Write SHALL occur when wr_valid & wr_ready & wr_addr < DEPTH; wr_valid with wr_ready=0 SHALL be dropped and increment drop_cnt.
REQ-026 wr_valid (or rd_en) with address >= DEPTH SHALL leave memory unchanged and set addr_err.
REQ-027 Read SHALL be accepted when rd_en & frame_ready; rd_en with frame_ready=0 SHALL produce no rd_valid.
REQ-028 Accepted read SHALL assert rd_valid with bank rb data after read latency L (L=1 base); out-of-range read returns rd_data=0 with rd_valid.
REQ-029 Read bank index SHALL be sampled at acceptance; a bank swap in the same cycle affects only later reads.
REQ-030 Write and read never target the same bank in the same cycle (by construction); no collision logic required.
REQ-031 rd_data SHALL hold last value when rd_valid=0.

Reset
REQ-032 rst_n=0 SHALL force state EMPTY, wb=0, rb=1, wr_ready=1 (after release), frame_ready=0, rd_valid=0, rd_data=0, drop_cnt=0, addr_err=0; memory contents undefined/unchanged.
REQ-033 Reset mid-frame SHALL discard all frame ownership; in-flight reads SHALL not produce rd_valid.

Configuration
REQ-034 Macro PINGPONG_OUTPUT_REG_EN defined: extra output register, L=2, rd_valid pipeline extended to match; undefined: L=1.

Verification
REQ-035 Reset, write 0..9 with data=addr+0x100, pulse wr_frame_done, read addr 5 -> frame_ready=1, rd_data=0x105 with rd_valid L cycles later.
REQ-036 Two wr_frame_done pulses without rd_frame_done -> state TWO, wr_ready=0; 3 further wr_valid -> drop_cnt=3, memory unchanged.
REQ-037 In ONE, wr_frame_done and rd_frame_done same cycle -> frame_ready stays 1, reads return newest frame data.
REQ-038 rd_en in EMPTY -> rd_valid stays 0; wr_addr=DEPTH -> addr_err=1, no write.
REQ-039 Assert rst_n=0 while in TWO with read pending -> next cycle frame_ready=0, rd_valid=0, drop_cnt=0, wr_ready=1.
REQ-040 Run REQ-035 with and without PINGPONG_OUTPUT_REG_EN -> rd_valid at cycle +2 and +1 respectively.

Source files
------------

// File: rtl/pingpong_frame_bram.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_frame_bram
//  Purpose  : Two-bank ping-pong frame buffer with writer/reader ownership FSM.
//             Optional macro PINGPONG_OUTPUT_REG_EN adds an output register
//             stage (read latency 2 instead of 1).
//  Revision : 1.0 - initial release
// ============================================================================
module pingpong_frame_bram #(
    parameter int DATA_WIDTH = 22,
    parameter int DEPTH      = 147708,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_frame_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_frame_done,
    output logic                  frame_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [15:0]           drop_cnt,
    output logic                  addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state;
    logic   wb;
    logic   rb;

    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic             rd_fire;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_fire     = wr_valid & wr_ready & wr_in_range;
    assign rd_fire     = rd_en & frame_ready;
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];

    // Bank ownership FSM; wr_ready/frame_ready are registered state decodes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            wb          <= 1'b0;
            rb          <= 1'b1;
            wr_ready    <= 1'b1;
            frame_ready <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (wr_frame_done) begin
                        state       <= ST_ONE;
                        rb          <= wb;
                        wb          <= ~wb;
                        frame_ready <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (wr_frame_done && rd_frame_done) begin
                        rb <= wb;
                        wb <= ~wb;
                    end else if (wr_frame_done) begin
                        state    <= ST_TWO;
                        wr_ready <= 1'b0;
                    end else if (rd_frame_done) begin
                        state       <= ST_EMPTY;
                        frame_ready <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (rd_frame_done) begin
                        state    <= ST_ONE;
                        rb       <= ~rb;
                        wb       <= rb;
                        wr_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    wb          <= 1'b0;
                    rb          <= 1'b1;
                    wr_ready    <= 1'b1;
                    frame_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bank storage: no reset so the arrays map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (wb) begin
                mem1[wr_idx] <= wr_data;
            end else begin
                mem0[wr_idx] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
            addr_err <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if ((wr_valid && !wr_in_range) || (rd_en && !rd_in_range)) begin
                addr_err <= 1'b1;
            end
        end
    end

`ifdef PINGPONG_OUTPUT_REG_EN
    logic                  rd_v1;
    logic                  rd_oor1;
    logic [DATA_WIDTH-1:0] rd_q1;

    // Stage 1 samples the bank index at acceptance, stage 2 is the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_v1    <= 1'b0;
            rd_oor1  <= 1'b0;
            rd_q1    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_v1 <= rd_fire;
            if (rd_fire) begin
                rd_oor1 <= ~rd_in_range;
                rd_q1   <= rb ? mem1[rd_idx] : mem0[rd_idx];
            end
            rd_valid <= rd_v1;
            if (rd_v1) begin
                rd_data <= rd_oor1 ? '0 : rd_q1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                if (rd_in_range) begin
                    rd_data <= rb ? mem1[rd_idx] : mem0[rd_idx];
                end else begin
                    rd_data <= '0;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
